// File: rtl/mem_wb_multi.sv
// MEM->WB pipeline register carrying NUM_CH register-write channels.
// MODE 0 follows the global stall vector; MODE 1 is a valid/ready stage with a 2-entry skid buffer.
module mem_wb_multi #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MODE      = 1,
  parameter int STALL_IN  = 3,
  parameter int STALL_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [5:0]               stall,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*ADDR_W-1:0] in_wd,
  input  logic [NUM_CH-1:0]        in_wreg,
  input  logic [NUM_CH*DATA_W-1:0] in_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*ADDR_W-1:0] out_wd,
  output logic [NUM_CH-1:0]        out_wreg,
  output logic [NUM_CH*DATA_W-1:0] out_wdata
);

  typedef struct packed {
    logic [NUM_CH*ADDR_W-1:0] wd;
    logic [NUM_CH-1:0]        wreg;
    logic [NUM_CH*DATA_W-1:0] wdata;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

  localparam bundle_t BUBBLE = '0;

  // A lower channel loses its write when a higher channel writes the same register.
  function automatic logic [NUM_CH-1:0] mask_wreg(input logic [NUM_CH*ADDR_W-1:0] wd,
                                                  input logic [NUM_CH-1:0] wreg);
    mask_wreg = wreg;
    for (int i = 0; i < NUM_CH; i++)
      for (int j = i + 1; j < NUM_CH; j++)
        if (wreg[i] && wreg[j] && (wd[i*ADDR_W +: ADDR_W] == wd[j*ADDR_W +: ADDR_W]))
          mask_wreg[i] = 1'b0;
  endfunction

  bundle_t in_b;
  bundle_t m_q;
  logic    unused_bits;

  assign in_b        = '{wd: in_wd, wreg: mask_wreg(in_wd, in_wreg), wdata: in_wdata};
  assign out_wd      = m_q.wd;
  assign out_wreg    = m_q.wreg;
  assign out_wdata   = m_q.wdata;
  assign unused_bits = ^{stall, in_valid, out_ready};

  generate
    if (MODE == 0) begin : g_stall
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          m_q <= BUBBLE;
        else if (flush)
          m_q <= BUBBLE;
        else if (stall[STALL_IN] && !stall[STALL_OUT])
          m_q <= BUBBLE;
        else if (!stall[STALL_IN])
          m_q <= in_b;
      end

      assign in_ready  = ~stall[STALL_IN];
      assign out_valid = |m_q.wreg;
    end else begin : g_skid
      skid_state_t state_q, state_d;
      bundle_t     s_q, s_d, m_d;
      logic        acc, deq;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= EMPTY;
          m_q     <= BUBBLE;
          s_q     <= BUBBLE;
        end else begin
          state_q <= state_d;
          m_q     <= m_d;
          s_q     <= s_d;
        end
      end

      // S only fills while M is stalled, and always drains into M before new input is taken.
      always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        acc     = in_valid & in_ready;
        deq     = out_valid & out_ready;
        if (flush) begin
          state_d = EMPTY;
          m_d     = BUBBLE;
          s_d     = BUBBLE;
        end else begin
          case (state_q)
            EMPTY: if (acc) begin
              m_d     = in_b;
              state_d = ONE;
            end
            ONE: begin
              if (deq && acc) begin
                m_d = in_b;
              end else if (deq) begin
                m_d     = BUBBLE;
                state_d = EMPTY;
              end else if (acc) begin
                s_d     = in_b;
                state_d = TWO;
              end
            end
            TWO: if (deq) begin
              m_d     = s_q;
              s_d     = BUBBLE;
              state_d = ONE;
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      assign in_ready  = (state_q != TWO);
      assign out_valid = (state_q != EMPTY);
    end
  endgenerate

endmodule

// File: tb/tb_mem_wb_multi.sv
// Self-checking bench: one MODE 0 and one MODE 1 instance share stimulus and are
// compared against a queue-based reference model.
module tb_mem_wb_multi;

  localparam int NCH = 2;
  localparam int AW  = 5;
  localparam int DW  = 32;

  typedef struct packed {
    logic [NCH*AW-1:0] wd;
    logic [NCH-1:0]    wreg;
    logic [NCH*DW-1:0] wdata;
  } bundle_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [5:0]        stall;
  logic              in_valid;
  logic              out_ready;
  logic [NCH*AW-1:0] in_wd;
  logic [NCH-1:0]    in_wreg;
  logic [NCH*DW-1:0] in_wdata;

  logic              o0_in_ready, o0_out_valid, o1_in_ready, o1_out_valid;
  logic [NCH*AW-1:0] o0_wd, o1_wd;
  logic [NCH-1:0]    o0_wreg, o1_wreg;
  logic [NCH*DW-1:0] o0_wdata, o1_wdata;

  int      pass_cnt = 0;
  int      total_cnt = 0;
  bundle_t e0;
  bundle_t q[$];

  mem_wb_multi #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_valid(in_valid),
    .in_ready(o0_in_ready), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .out_valid(o0_out_valid), .out_ready(out_ready), .out_wd(o0_wd),
    .out_wreg(o0_wreg), .out_wdata(o0_wdata)
  );

  mem_wb_multi #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_valid(in_valid),
    .in_ready(o1_in_ready), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .out_valid(o1_out_valid), .out_ready(out_ready), .out_wd(o1_wd),
    .out_wreg(o1_wreg), .out_wdata(o1_wdata)
  );

  always #5 clk = ~clk;

  // Walk from the highest channel down; an address already claimed loses its write.
  function automatic logic [NCH-1:0] ref_mask(input logic [NCH*AW-1:0] wd,
                                              input logic [NCH-1:0] wreg);
    bit claimed[int];
    int a;
    ref_mask = '0;
    for (int ch = NCH - 1; ch >= 0; ch--) begin
      a = int'(wd[ch*AW +: AW]);
      if (wreg[ch]) begin
        if (!claimed.exists(a)) ref_mask[ch] = 1'b1;
        claimed[a] = 1'b1;
      end
    end
  endfunction

  task automatic set_in(input logic [NCH*AW-1:0] wd, input logic [NCH-1:0] wreg,
                        input logic [NCH*DW-1:0] wdata);
    in_wd    = wd;
    in_wreg  = wreg;
    in_wdata = wdata;
  endtask

  // Update the reference model from the inputs now applied, then take the clock edge.
  task automatic advance();
    bundle_t nb;
    int      sz;
    nb = '{wd: in_wd, wreg: ref_mask(in_wd, in_wreg), wdata: in_wdata};
    sz = q.size();
    if (flush || (stall[3] && !stall[4])) e0 = '0;
    else if (!stall[3]) e0 = nb;
    if (flush) q.delete();
    else begin
      if (out_ready && sz > 0) q.delete(0);
      if (in_valid && sz < 2) q.push_back(nb);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; stall = '0; in_valid = 1'b0; out_ready = 1'b0;
    set_in('0, '0, '0);
    e0 = '0;
    q.delete();
    #12;
    total_cnt++; if ({o0_wd, o0_wreg, o0_wdata} !== '0) $display("[TB] FAIL reset_m0_fields got %0h want 0", {o0_wd, o0_wreg, o0_wdata}); else pass_cnt++;
    total_cnt++; if ({o1_wd, o1_wreg, o1_wdata} !== '0) $display("[TB] FAIL reset_m1_fields got %0h want 0", {o1_wd, o1_wreg, o1_wdata}); else pass_cnt++;
    total_cnt++; if (o1_out_valid !== 1'b0 || o0_out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b%b want 00", o0_out_valid, o1_out_valid); else pass_cnt++;
    total_cnt++; if (o1_in_ready !== 1'b1 || o0_in_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b%b want 11", o0_in_ready, o1_in_ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mode0_capture();
    stall = '0; in_valid = 1'b1; out_ready = 1'b1;
    set_in({5'd0, 5'd5}, 2'b01, {32'h0, 32'h1234});
    advance();
    @(negedge clk);
    total_cnt++; if (o0_wd[4:0] !== 5'd5) $display("[TB] FAIL t1_wd got %0d want 5", o0_wd[4:0]); else pass_cnt++;
    total_cnt++; if (o0_wreg !== 2'b01) $display("[TB] FAIL t1_wreg got %b want 01", o0_wreg); else pass_cnt++;
    total_cnt++; if (o0_wdata[31:0] !== 32'h1234) $display("[TB] FAIL t1_wdata got %h want 1234", o0_wdata[31:0]); else pass_cnt++;
    total_cnt++; if (o0_out_valid !== 1'b1) $display("[TB] FAIL t1_valid got %b want 1", o0_out_valid); else pass_cnt++;
    total_cnt++; if (o1_out_valid !== 1'b1 || o1_wdata[31:0] !== 32'h1234) $display("[TB] FAIL t1_m1 got %b/%h want 1/1234", o1_out_valid, o1_wdata[31:0]); else pass_cnt++;
  endtask

  task automatic test_mode0_stall();
    stall = 6'b001000;
    set_in({5'd0, 5'd6}, 2'b01, {32'h0, 32'h4444});
    #1;
    total_cnt++; if (o0_in_ready !== 1'b0) $display("[TB] FAIL t2_ready got %b want 0", o0_in_ready); else pass_cnt++;
    advance();
    @(negedge clk);
    total_cnt++; if (o0_wreg !== 2'b00 || o0_wdata !== '0) $display("[TB] FAIL t2_bubble got %b/%h want 00/0", o0_wreg, o0_wdata); else pass_cnt++;
    total_cnt++; if (o0_out_valid !== 1'b0) $display("[TB] FAIL t2_bubble_valid got %b want 0", o0_out_valid); else pass_cnt++;
    stall = '0;
    set_in({5'd0, 5'd9}, 2'b01, {32'h0, 32'h5555});
    advance();
    @(negedge clk);
    stall = 6'b011000;
    set_in({5'd0, 5'd10}, 2'b01, {32'h0, 32'h6666});
    advance();
    @(negedge clk);
    total_cnt++; if (o0_wdata[31:0] !== 32'h5555 || o0_wreg !== 2'b01) $display("[TB] FAIL t2_hold got %b/%h want 01/5555", o0_wreg, o0_wdata[31:0]); else pass_cnt++;
    stall = '0;
  endtask

  task automatic test_conflict();
    set_in({5'd7, 5'd7}, 2'b11, {32'hBBBB, 32'hAAAA});
    advance();
    @(negedge clk);
    total_cnt++; if (o0_wreg !== 2'b10) $display("[TB] FAIL t3_m0_wreg got %b want 10", o0_wreg); else pass_cnt++;
    total_cnt++; if (o0_wdata[63:32] !== 32'hBBBB) $display("[TB] FAIL t3_ch1_data got %h want bbbb", o0_wdata[63:32]); else pass_cnt++;
    total_cnt++; if (o1_wreg !== 2'b10) $display("[TB] FAIL t3_m1_wreg got %b want 10", o1_wreg); else pass_cnt++;
    set_in({5'd7, 5'd7}, 2'b10, {32'hBBBB, 32'hAAAA});
    advance();
    @(negedge clk);
    total_cnt++; if (o0_wreg !== 2'b10) $display("[TB] FAIL t3_ch0_off got %b want 10", o0_wreg); else pass_cnt++;
    set_in({5'd7, 5'd7}, 2'b01, {32'hBBBB, 32'hAAAA});
    advance();
    @(negedge clk);
    total_cnt++; if (o0_wreg !== 2'b01) $display("[TB] FAIL t3_ch1_off got %b want 01", o0_wreg); else pass_cnt++;
    set_in({5'd8, 5'd7}, 2'b11, {32'hBBBB, 32'hAAAA});
    advance();
    @(negedge clk);
    total_cnt++; if (o0_wreg !== 2'b11 || o1_wreg !== 2'b11) $display("[TB] FAIL t3_distinct got %b/%b want 11/11", o0_wreg, o1_wreg); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[3];
    in_valid = 1'b0; out_ready = 1'b1;
    advance();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0;
    set_in({5'd2, 5'd1}, 2'b01, {32'h0, 32'hA0});
    advance();
    @(negedge clk);
    set_in({5'd2, 5'd1}, 2'b01, {32'h0, 32'hB0});
    advance();
    @(negedge clk);
    total_cnt++; if (o1_wdata[31:0] !== 32'hA0 || o1_in_ready !== 1'b0) $display("[TB] FAIL t4_full got %h/%b want a0/0", o1_wdata[31:0], o1_in_ready); else pass_cnt++;
    set_in({5'd2, 5'd1}, 2'b01, {32'h0, 32'hC0});
    advance();
    @(negedge clk);
    total_cnt++; if (o1_wdata[31:0] !== 32'hA0 || o1_in_ready !== 1'b0) $display("[TB] FAIL t4_stable got %h/%b want a0/0", o1_wdata[31:0], o1_in_ready); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      got[k] = o1_out_valid ? o1_wdata[31:0] : 32'hDEAD;
      if (k == 2) in_valid = 1'b0;
      advance();
      @(negedge clk);
    end
    total_cnt++; if (got[0] !== 32'hA0) $display("[TB] FAIL t4_first got %h want a0", got[0]); else pass_cnt++;
    total_cnt++; if (got[1] !== 32'hB0) $display("[TB] FAIL t4_second got %h want b0", got[1]); else pass_cnt++;
    total_cnt++; if (got[2] !== 32'hC0) $display("[TB] FAIL t4_third got %h want c0", got[2]); else pass_cnt++;
    total_cnt++; if (o1_out_valid !== 1'b0) $display("[TB] FAIL t4_drained got %b want 0", o1_out_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b0;
    set_in({5'd4, 5'd3}, 2'b11, {32'hD1, 32'hD0});
    advance();
    @(negedge clk);
    set_in({5'd4, 5'd3}, 2'b11, {32'hE1, 32'hE0});
    advance();
    @(negedge clk);
    total_cnt++; if (o1_in_ready !== 1'b0) $display("[TB] FAIL t5_full got %b want 0", o1_in_ready); else pass_cnt++;
    flush = 1'b1;
    set_in({5'd4, 5'd3}, 2'b11, {32'hF1, 32'hF0});
    advance();
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++; if (o1_out_valid !== 1'b0 || o1_in_ready !== 1'b1) $display("[TB] FAIL t5_after got %b/%b want 0/1", o1_out_valid, o1_in_ready); else pass_cnt++;
    total_cnt++; if (o0_out_valid !== 1'b0 || o0_wdata !== '0) $display("[TB] FAIL t5_m0_bubble got %b/%h want 0/0", o0_out_valid, o0_wdata); else pass_cnt++;
    out_ready = 1'b1;
    advance();
    @(negedge clk);
    total_cnt++; if (o1_out_valid !== 1'b0) $display("[TB] FAIL t5_no_ghost got %b want 0", o1_out_valid); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    set_in({5'd1, 5'd2}, 2'b11, {32'h98, 32'h99});
    advance();
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++; if (o1_out_valid !== 1'b1) $display("[TB] FAIL t6_loaded got %b want 1", o1_out_valid); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (o1_out_valid !== 1'b0 || {o1_wd, o1_wreg, o1_wdata} !== '0) $display("[TB] FAIL t6_m1_cleared got %b/%h want 0/0", o1_out_valid, o1_wdata); else pass_cnt++;
    total_cnt++; if ({o0_wd, o0_wreg, o0_wdata} !== '0) $display("[TB] FAIL t6_m0_cleared got %h want 0", o0_wdata); else pass_cnt++;
    q.delete();
    e0 = '0;
    #1 rst = 1'b1;
    #0;
    total_cnt++; if (o1_in_ready !== 1'b1) $display("[TB] FAIL t6_ready got %b want 1", o1_in_ready); else pass_cnt++;
    advance();
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      total_cnt++; if (o1_out_valid !== (q.size() > 0)) $display("[TB] FAIL rnd_m1_valid cyc %0d got %b want %b", n, o1_out_valid, q.size() > 0); else pass_cnt++;
      total_cnt++; if (o1_in_ready !== (q.size() < 2)) $display("[TB] FAIL rnd_m1_ready cyc %0d got %b want %b", n, o1_in_ready, q.size() < 2); else pass_cnt++;
      if (q.size() > 0) begin
        total_cnt++; if ({o1_wd, o1_wreg, o1_wdata} !== q[0]) $display("[TB] FAIL rnd_m1_data cyc %0d got %h want %h", n, {o1_wd, o1_wreg, o1_wdata}, q[0]); else pass_cnt++;
      end
      total_cnt++; if ({o0_wd, o0_wreg, o0_wdata} !== e0) $display("[TB] FAIL rnd_m0_data cyc %0d got %h want %h", n, {o0_wd, o0_wreg, o0_wdata}, e0); else pass_cnt++;
      total_cnt++; if (o0_out_valid !== (|e0.wreg)) $display("[TB] FAIL rnd_m0_valid cyc %0d got %b want %b", n, o0_out_valid, |e0.wreg); else pass_cnt++;
      flush     = ($urandom_range(0, 15) == 0);
      stall     = 6'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_in({5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}, 2'($urandom), {$urandom, $urandom});
      #1;
      total_cnt++; if (o0_in_ready !== ~stall[3]) $display("[TB] FAIL rnd_m0_ready cyc %0d got %b want %b", n, o0_in_ready, ~stall[3]); else pass_cnt++;
      advance();
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_capture();
    test_mode0_stall();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
